image_sharpening: RTL and testbench
===================================

// Module: image_sharpening
// PURPOSE
//   Streaming 3x3 Laplacian sharpening filter for one greyscale frame.
//   Accepts one 8-bit pixel per clock in raster order; emits one signed sharpened pixel per clock.
//   Outputs are qualified by en_out, with a fixed pipeline latency.
//   Sits between a pixel source (file/camera reader) and a result sink; no back-pressure.
// PARAMETERS
//   WIDTH   128  pixels per row
//   HEIGHT  128  rows per frame (frame = WIDTH*HEIGHT = 16384 pixels)
//   PIX_W   8    input pixel width, unsigned
//   OUT_W   10   output width, two's-complement signed
// PORTS
//   clk           in   1      clock; all state changes on rising edge
//   rst_n         in   1      reset, asynchronous, active-low
//   input_img     in   PIX_W  unsigned input pixel, MSB-first; sampled every rising edge while capturing
//   sharpend_img  out  OUT_W  signed sharpened pixel; valid only while en_out=1
//   en_out        out  1      high for exactly WIDTH*HEIGHT consecutive cycles, one per output pixel
// BEHAVIOUR
//   Reset (rst_n=0, async): sharpend_img=0, en_out=0, all counters/line buffers cleared, state=CAPTURE.
//   Capture: the first rising edge with rst_n=1 samples pixel 0; each later edge samples the next pixel.
//     There is no input-valid signal; the source must present a new pixel every cycle.
//   Kernel: out(r,c) = 5*P(r,c) - P(r-1,c) - P(r+1,c) - P(r,c-1) - P(r,c+1).
//   Borders: neighbours outside the frame read as 0 (zero padding); no wrap across row ends.
//   Arithmetic: computed at >=12-bit signed, full precision.
//     Result is saturated to [-512, 511] before output.
//   Storage: a (2*WIDTH+1)-deep pixel delay line (or two row buffers plus taps) holds N, W, C, E, S.
//   Latency: pixel k (k = r*WIDTH + c) is sampled at edge k.
//     Its result is registered at edge k+WIDTH+1 and held until the next edge.
//     So en_out first rises at edge WIDTH+1 (edge 129 for the default 128x128 frame).
//   Flush: after pixel WIDTH*HEIGHT-1 is sampled, input_img is ignored.
//     The last row's south neighbours are 0; output continues for WIDTH+1 more cycles.
//   States: CAPTURE (sampling, outputs start after fill) -> FLUSH (no sampling, outputs continue)
//     -> DONE (en_out=0, sharpend_img holds 0) until rst_n is asserted again.
//     Exactly one frame is processed per reset.
//   en_out is asserted continuously from the first to the last output, with no gaps.
//     It drops on the edge following the last output.
//   Reset mid-frame: outputs and en_out clear immediately (async).
//     A fresh frame starts at the first edge after release; partial data is discarded.
// TESTING
//   All-zero frame -> en_out high 16384 consecutive cycles starting edge 129; every output 0.
//   Uniform 100 frame -> interior 100; non-corner edges 200; four corners 300.
//   Uniform 255 frame -> interior 255; non-corner edges 510; corners 765 saturated to 511.
//   Impulse 50 at (10,10), rest 0 -> out(10,10)=250.
//     (9,10), (11,10), (10,9), (10,11) = -50; all others 0.
//   Impulse 50 at (0,127) -> out(0,127)=250; (0,126) and (1,127) = -50; (1,0) is 0 (no row wrap).
//   rst_n pulsed low at pixel 5000 -> en_out/sharpend_img 0 at once.
//     A full new frame then outputs 16384 values, first valid at edge 129 after release.
//   After the last output, en_out stays 0 and input changes produce no output until the next reset.

Source files
------------

// File: rtl/image_sharpening_if.sv
// Pixel stream bundle between the source/sink side and the sharpening filter.
interface image_sharpening_if #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned OUT_W = 10
);
   logic        [PIX_W-1:0] input_img;
   logic signed [OUT_W-1:0] sharpend_img;
   logic                    en_out;

   // Source/sink side: drives pixels, observes results
   modport master (
      output input_img,
      input  sharpend_img,
      input  en_out
   );

   // Filter side: consumes pixels, produces results
   modport slave (
      input  input_img,
      output sharpend_img,
      output en_out
   );
endinterface

// File: rtl/image_sharpening.sv
// Streaming 3x3 Laplacian sharpening filter: one pixel in and one saturated
// signed result out per clock, processing exactly one frame per reset.
module image_sharpening #(
   parameter int unsigned WIDTH  = 128,
   parameter int unsigned HEIGHT = 128,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned OUT_W  = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   image_sharpening_if.slave  bus
);

   localparam int unsigned FRAME     = WIDTH * HEIGHT;
   localparam int unsigned DEPTH     = 2 * WIDTH + 1;
   localparam int unsigned FILL_EDGE = WIDTH + 1;
   localparam int unsigned LAST_EDGE = FRAME + WIDTH;
   localparam int unsigned CNT_W     = $clog2(LAST_EDGE + 2);
   localparam int unsigned COL_W     = $clog2(WIDTH);
   localparam int unsigned ROW_W     = $clog2(HEIGHT);
   localparam int unsigned SUM_W     = PIX_W + 4;

   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (OUT_W - 1)));

   typedef enum logic [1:0] {
      S_CAPTURE = 2'd0,
      S_FLUSH   = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic [CNT_W-1:0]        r_ecnt;
   logic [COL_W-1:0]        r_col;
   logic [ROW_W-1:0]        r_row;
   logic [PIX_W-1:0]        r_line [DEPTH];
   logic signed [OUT_W-1:0] r_pix;
   logic                    r_en;

   logic                    w_shift;
   logic                    w_sample;
   logic                    w_emit;
   logic signed [SUM_W-1:0] w_c;
   logic signed [SUM_W-1:0] w_n;
   logic signed [SUM_W-1:0] w_s;
   logic signed [SUM_W-1:0] w_w;
   logic signed [SUM_W-1:0] w_e;
   logic signed [SUM_W-1:0] w_sum;
   logic signed [SUM_W-1:0] w_clamp;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_CAPTURE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: leave capture on the last sampled pixel, finish on the last output
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_CAPTURE: if (r_ecnt == CNT_W'(FRAME - 1)) w_next_state = S_FLUSH;
         S_FLUSH:   if (r_ecnt == CNT_W'(LAST_EDGE)) w_next_state = S_DONE;
         S_DONE:    w_next_state = S_DONE;
         default:   w_next_state = S_CAPTURE;
      endcase
   end

   // Per-state controls; results start once the delay line holds a full south neighbour
   always_comb begin
      w_shift  = 1'b0;
      w_sample = 1'b0;
      w_emit   = 1'b0;
      case (r_state)
         S_CAPTURE: begin
            w_shift  = 1'b1;
            w_sample = 1'b1;
            w_emit   = (r_ecnt >= CNT_W'(FILL_EDGE));
         end
         S_FLUSH: begin
            w_shift  = 1'b1;
            w_emit   = (r_ecnt >= CNT_W'(FILL_EDGE));
         end
         default: begin
            w_shift  = 1'b0;
         end
      endcase
   end

   // Edge counter since reset release; frozen once the frame is done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ecnt <= '0;
      end else if (w_shift) begin
         r_ecnt <= r_ecnt + CNT_W'(1);
      end
   end

   // Pixel delay line; zeros are shifted in during flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_line[i] <= '0;
         end
      end else if (w_shift) begin
         r_line[0] <= w_sample ? bus.input_img : '0;
         for (int i = 1; i < DEPTH; i++) begin
            r_line[i] <= r_line[i-1];
         end
      end
   end

   // Row/column of the centre pixel whose result is produced next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_emit) begin
         if (r_col == COL_W'(WIDTH - 1)) begin
            r_col <= '0;
            r_row <= r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end
      end
   end

   // Kernel taps with zero padding at frame borders (no wrap across row ends)
   always_comb begin
      w_c = SUM_W'(r_line[WIDTH]);
      w_n = (r_row != '0)                  ? SUM_W'(r_line[2*WIDTH])   : '0;
      w_s = (r_row != ROW_W'(HEIGHT - 1))  ? SUM_W'(r_line[0])         : '0;
      w_w = (r_col != '0)                  ? SUM_W'(r_line[WIDTH + 1]) : '0;
      w_e = (r_col != COL_W'(WIDTH - 1))   ? SUM_W'(r_line[WIDTH - 1]) : '0;
   end

   // Full-precision Laplacian sharpen followed by saturation to the output range
   always_comb begin
      w_sum   = (w_c <<< 2) + w_c - w_n - w_s - w_w - w_e;
      w_clamp = w_sum;
      if (w_sum > SAT_MAX) begin
         w_clamp = SAT_MAX;
      end else if (w_sum < SAT_MIN) begin
         w_clamp = SAT_MIN;
      end
   end

   // Registered result and qualifier; result reads 0 whenever not qualified
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix <= '0;
         r_en  <= 1'b0;
      end else begin
         r_pix <= w_emit ? OUT_W'(w_clamp) : '0;
         r_en  <= w_emit;
      end
   end

   assign bus.sharpend_img = r_pix;
   assign bus.en_out       = r_en;

endmodule

// File: tb/tb_image_sharpening.sv
// Directed bench for the streaming sharpening filter.
module tb_image_sharpening;

   localparam int W  = 128;
   localparam int H  = 128;
   localparam int N  = W * H;

   logic clk;
   logic rst_n;

   int n_vec;
   int n_err;
   int first_en;
   int en_cnt;
   logic signed [9:0] frame_out [N];

   image_sharpening_if #(.PIX_W(8), .OUT_W(10)) bus ();

   image_sharpening #(
      .WIDTH (W),
      .HEIGHT(H),
      .PIX_W (8),
      .OUT_W (10)
   ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pattern 0: impulses of 50 at (10,10) and (0,127); 1: uniform 100; 2: uniform 255
   function automatic int pixel(input int pat, input int r, input int c);
      if (r < 0 || r >= H || c < 0 || c >= W) return 0;
      case (pat)
         0: return ((r == 10 && c == 10) || (r == 0 && c == 127)) ? 50 : 0;
         1: return 100;
         default: return 255;
      endcase
   endfunction

   function automatic int model(input int pat, input int r, input int c);
      int v;
      v = 5 * pixel(pat, r, c) - pixel(pat, r - 1, c) - pixel(pat, r + 1, c)
          - pixel(pat, r, c - 1) - pixel(pat, r, c + 1);
      if (v > 511) v = 511;
      if (v < -512) v = -512;
      return v;
   endfunction

   task automatic check(input string tag, input int obs, input int expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      #1;
      check("rst_en_out", int'(bus.en_out), 0);
      check("rst_img", int'(bus.sharpend_img), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Runs one complete frame from the edge after reset release; checks every cycle
   task automatic run_frame(input int pat);
      int k;
      int exp_en;
      first_en = -1;
      en_cnt   = 0;
      for (int e = 0; e < N + W + 6; e++) begin
         if (e < N) bus.input_img = 8'(pixel(pat, e / W, e % W));
         else       bus.input_img = 8'($urandom);
         @(posedge clk);
         #1;
         exp_en = (e >= W + 1 && e <= N + W) ? 1 : 0;
         check("en_out", int'(bus.en_out), exp_en);
         if (bus.en_out === 1'b1) begin
            if (first_en < 0) first_en = e;
            en_cnt++;
         end
         if (exp_en == 1) begin
            k = e - W - 1;
            frame_out[k] = bus.sharpend_img;
            check("pix", int'(bus.sharpend_img), model(pat, k / W, k % W));
         end else begin
            check("idle_img", int'(bus.sharpend_img), 0);
         end
      end
      check("first_en_edge", first_en, W + 1);
      check("en_count", en_cnt, N);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      bus.input_img = '0;
      rst_n = 1'b0;
      #2;
      check("reset_en_out", int'(bus.en_out), 0);
      check("reset_img", int'(bus.sharpend_img), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Uniform 100 frame aborted by reset at pixel 5000
      for (int e = 0; e <= 5000; e++) begin
         bus.input_img = 8'd100;
         @(posedge clk);
         #1;
      end
      check("mid_en_out", int'(bus.en_out), 1);
      check("mid_img", int'(bus.sharpend_img), 100);
      reset_pulse();

      // Fresh frame with impulses
      run_frame(0);
      check("imp_center", int'(frame_out[10*W + 10]), 250);
      check("imp_north", int'(frame_out[9*W + 10]), -50);
      check("imp_south", int'(frame_out[11*W + 10]), -50);
      check("imp_west", int'(frame_out[10*W + 9]), -50);
      check("imp_east", int'(frame_out[10*W + 11]), -50);
      check("imp_far", int'(frame_out[50*W + 50]), 0);
      check("edge_center", int'(frame_out[127]), 250);
      check("edge_west", int'(frame_out[126]), -50);
      check("edge_south", int'(frame_out[W + 127]), -50);
      check("no_row_wrap", int'(frame_out[W]), 0);

      // Post-frame: input activity must produce nothing
      for (int i = 0; i < 200; i++) begin
         bus.input_img = 8'($urandom);
         @(posedge clk);
         #1;
         check("done_en_out", int'(bus.en_out), 0);
         check("done_img", int'(bus.sharpend_img), 0);
      end

      reset_pulse();
      run_frame(1);
      check("u100_corner", int'(frame_out[0]), 300);
      check("u100_corner_br", int'(frame_out[N - 1]), 300);
      check("u100_edge", int'(frame_out[5]), 200);
      check("u100_edge_w", int'(frame_out[64*W]), 200);
      check("u100_interior", int'(frame_out[5*W + 5]), 100);

      reset_pulse();
      run_frame(2);
      check("u255_corner_sat", int'(frame_out[N - 1]), 511);
      check("u255_corner_tr", int'(frame_out[127]), 511);
      check("u255_edge", int'(frame_out[64*W]), 510);
      check("u255_interior", int'(frame_out[64*W + 64]), 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
